// File: rtl/seq_multiplier32bu_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and default sizing.
`ifndef SEQ_MULTIPLIER32BU_PKG_SV
`define SEQ_MULTIPLIER32BU_PKG_SV
package seq_multiplier32bu_pkg;

   localparam int SEQMUL_WIDTH = 32;
   localparam int SEQMUL_CNT_W = 6;

   typedef enum logic [1:0] {
      SEQMUL_IDLE = 2'd0,
      SEQMUL_RUN  = 2'd1,
      SEQMUL_DONE = 2'd2
   } seqmul_state_e;

endpackage
`endif

// File: rtl/seq_multiplier32bu_if.sv
// Request/response bundle between the MDU controller (master) and the multiplier (slave).
// start is sampled only while ready=1; done pulses one cycle with prod valid; prod holds until the next accept.
interface seq_multiplier32bu_if
   import seq_multiplier32bu_pkg::*;
#(
   parameter int WIDTH = SEQMUL_WIDTH
) ();

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 ready;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prod;
   seqmul_state_e        state;

   modport master (
      output start, a, b,
      input  ready, busy, done, prod, state
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, prod, state
   );

endinterface

// File: rtl/seq_multiplier32bu_control.sv
// Control FSM for the multiplier: state register, step counter, load/step enables
// and Moore-decoded ready/busy/done.
module seq_multiplier_control
   import seq_multiplier32bu_pkg::*;
#(
   parameter int WIDTH = SEQMUL_WIDTH,
   parameter int CNT_W = SEQMUL_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          load,
   output logic          step,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output seqmul_state_e state
);

   seqmul_state_e    state_next;
   logic [CNT_W-1:0] count;
   logic             last_step;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SEQMUL_IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            count <= '0;
         end else if (step) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign last_step = (count == CNT_W'(WIDTH - 1));

   // Status comes from the state register alone, so load is the only path from start.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         SEQMUL_IDLE: begin
            ready = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = SEQMUL_RUN;
            end
         end
         SEQMUL_RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last_step) begin
               state_next = SEQMUL_DONE;
            end
         end
         SEQMUL_DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = SEQMUL_RUN;
            end else begin
               state_next = SEQMUL_IDLE;
            end
         end
         default: begin
            state_next = SEQMUL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/seq_multiplier32bu.sv
// Unsigned shift-add multiplier, one partial-product step per clock, full 2*WIDTH-bit result.
// The product register doubles as the multiplier shift register: b starts in the low half.
module seq_multiplier32bu
   import seq_multiplier32bu_pkg::*;
#(
   parameter int WIDTH = SEQMUL_WIDTH,
   parameter int CNT_W = SEQMUL_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_multiplier32bu_if.slave  bus
);

   logic                 load;
   logic                 step;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH:0]       sum;

   seq_multiplier_control #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_control (
      .clk   (clk),
      .rst   (rst),
      .start (bus.start),
      .load  (load),
      .step  (step),
      .ready (bus.ready),
      .busy  (bus.busy),
      .done  (bus.done),
      .state (bus.state)
   );

   // Extra adder bit keeps the carry, which shifts into the product MSB.
   assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         mcand <= '0;
         prod  <= '0;
      end else if (load) begin
         mcand <= bus.a;
         prod  <= {{WIDTH{1'b0}}, bus.b};
      end else if (step) begin
         prod <= {sum, prod[WIDTH-1:1]};
      end
   end

   assign bus.prod = prod;

endmodule

// File: doc/seq_multiplier32bu.md
Name: seq_multiplier32bu

Overview:
Unsigned sequential shift-add multiplier. The multiply-side counterpart to the restoring divider, for the same ALU/MDU datapath.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit unsigned operands, one step per clock.
- Uses a start/ready/done handshake so the MDU controller can sequence mul and div the same way.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits
CNT_W, 6, step-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low (0 = reset on next rising clk edge)
start  input  1  request a multiply; sampled only when ready=1
a  input  WIDTH  multiplicand, captured on the accepting edge
b  input  WIDTH  multiplier, captured on the accepting edge
ready  output  1  block can accept start (state IDLE or DONE)
busy  output  1  multiply in progress (state RUN)
done  output  1  high for exactly one cycle when product becomes valid
prod  output  2*WIDTH  product {hi, lo}; held stable from done until the next accepted start

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, prod=0, count=0, multiplicand reg=0.
  - ready=1, busy=0, done=0.
  - Reset has priority over everything, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
- Accept (edge with ready=1 and start=1):
  - mcand<=a.
  - prod<={WIDTH'b0, b}.
  - count<=0.
  - state<=RUN.
  - a and b are not observed afterwards.
- RUN step (every edge in RUN):
  - sum[WIDTH:0] = prod[0] ? ({1'b0, prod[2W-1:W]} + {1'b0, mcand}) : {1'b0, prod[2W-1:W]}.
  - prod <= {sum, prod[W-1:1]}, i.e. right shift with the add carry entering the MSB.
  - count<=count+1.
  - When count==WIDTH-1 on this edge: state<=DONE.
- Latency: exactly WIDTH RUN steps.
  - With the accept edge as E0, the final step occurs at edge E_WIDTH.
  - done=1 during the cycle following E_WIDTH (WIDTH+1 edges after accept).
- DONE:
  - done=1, ready=1, busy=0.
  - With start=1: accept as above, state<=RUN. This gives back-to-back ops with no idle gap; done still pulses for exactly one cycle.
  - With start=0: state<=IDLE. prod stays held.
- IDLE: done=0, prod held.
- start while busy=1 is ignored: no queuing, no restart, operands unchanged.
- Outputs busy, ready and done are decoded from the state register only (Moore); no combinational path from start.
- Boundary results:
  - a=0 or b=0 gives prod=0.
  - The carry bit must be retained; max*max needs all 2*WIDTH bits.

Decomposition:
- Shared package/include (`ifndef guarded):
  - State encodings SEQMUL_IDLE=2'd0, SEQMUL_RUN=2'd1, SEQMUL_DONE=2'd2.
  - Default WIDTH.
- One sub-module, seq_multiplier_control:
  - Holds the state register and step counter.
  - Drives load/step enables plus ready/busy/done.
  - Takes clk, rst and start.
- The top holds the datapath: mcand register, prod register, and a (WIDTH+1)-bit adder with carry.

Test Plan:
- Basic multiply: rst low 2 cycles; then a=3, b=5, start pulse.
  - done rises exactly 33 edges after accept.
  - prod=64'h0000_0000_0000_000F; busy high for 32 cycles.
- Max operands: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF.
  - prod=64'hFFFF_FFFE_0000_0001, proving carry retention.
- Zero and mixed:
  - a=0, b=32'h1234_5678 gives prod=0.
  - a=32'h8000_0000, b=2 gives prod=64'h0000_0001_0000_0000.
- Start while busy: accept 7*9, then pulse start with a=b=1 at step 10.
  - The pulse is ignored; prod=64'd63 at the single done pulse.
- Back-to-back and mid-op reset:
  - Hold start high with 6*7 then 11*13. Expect done pulses 33 cycles apart, prod=42 then 143, no IDLE cycle between.
  - Then rst=0 mid-RUN: next cycle shows prod=0, done=0, ready=1.
  - After rst returns high, a new start completes normally.
